// File: rtl/wb_stream_writer_ctrl_if.sv
// rtl/wb_stream_writer_ctrl_if.sv - Wishbone read-master and stream FIFO write bundle
//
// Purpose: groups the Wishbone master signals and the downstream FIFO write
// port of wb_stream_writer_ctrl.
// Modports:
//   master : controller side (drives wbm_* requests, fifo_d/fifo_wr; reads
//            wbm_dat_i/ack/err and fifo_cnt)
//   slave  : bus/FIFO side (the mirror image)
interface wb_stream_writer_ctrl_if #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 4
);
  logic [WB_AW-1:0]   wbm_adr_o;
  logic [WB_DW-1:0]   wbm_dat_o;
  logic [WB_DW/8-1:0] wbm_sel_o;
  logic               wbm_we_o;
  logic               wbm_cyc_o;
  logic               wbm_stb_o;
  logic [2:0]         wbm_cti_o;
  logic [1:0]         wbm_bte_o;
  logic [WB_DW-1:0]   wbm_dat_i;
  logic               wbm_ack_i;
  logic               wbm_err_i;
  logic [WB_DW-1:0]   fifo_d;
  logic               fifo_wr;
  logic [FIFO_AW:0]   fifo_cnt;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_cti_o, wbm_bte_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output fifo_d, fifo_wr,
    input  fifo_cnt
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_cti_o, wbm_bte_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  fifo_d, fifo_wr,
    output fifo_cnt
  );
endinterface

// File: rtl/wb_stream_writer_ctrl.sv
// rtl/wb_stream_writer_ctrl.sv - Wishbone burst-read master filling a stream FIFO from a circular buffer
//
// Purpose: reads a memory buffer once per enable pulse in fixed-length linear
// bursts, starting a burst only when the FIFO can hold all of it, and writes
// every acknowledged word into the FIFO.
// Ports:
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   bus                : Wishbone master + FIFO write port (master modport)
//   busy, err          : transfer in progress, sticky bus-error flag
//   enable             : start request (ignored while busy)
//   tx_cnt             : word index of the next beat
//   start_adr, buf_size, burst_size : buffer base (bytes), size (bytes), words per burst
module wb_stream_writer_ctrl #(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int FIFO_AW       = 4,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  wb_stream_writer_ctrl_if.master   bus,
  output logic                      busy,
  output logic                      err,
  input  logic                      enable,
  output logic [WB_AW-1:0]          tx_cnt,
  input  logic [WB_AW-1:0]          start_adr,
  input  logic [WB_AW-1:0]          buf_size,
  input  logic [WB_AW-1:0]          burst_size
);

  localparam int LG_BPW = $clog2(WB_DW / 8);
  localparam int BCW    = $clog2(MAX_BURST_LEN) + 1;
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             cyc_q, cyc_d;
  logic [WB_AW-1:0] tx_cnt_q, tx_cnt_d;
  logic [BCW-1:0]   burst_cnt_q, burst_cnt_d;

  logic [WB_AW-1:0] words;
  logic             last_adr;
  logic [FIFO_AW:0] space;
  logic             space_ok;
  logic             burst_end;

  assign words    = buf_size >> LG_BPW;
  assign last_adr = (tx_cnt_q == words - 1'b1);
  // Free FIFO slots, widened before comparing so large burst_size values never alias.
  assign space    = DEPTH - bus.fifo_cnt;
  assign space_ok = ({{(WB_AW-FIFO_AW-1){1'b0}}, space} >= burst_size);
  // A burst closes on its programmed length or at the buffer end, whichever comes first.
  assign burst_end = ({{(WB_AW-BCW){1'b0}}, burst_cnt_q} == burst_size - 1'b1) | last_adr;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    err_d       = err_q;
    tx_cnt_d    = tx_cnt_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        burst_cnt_d = '0;
        if (enable && !busy_q) begin
          busy_d = 1'b1;
          err_d  = 1'b0;
        end
        // Uses the registered busy, so the first burst starts one edge after enable.
        if (busy_q && space_ok && (burst_size != '0)) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (bus.wbm_err_i) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (bus.wbm_ack_i) begin
          burst_cnt_d = burst_cnt_q + BCW'(1);
          tx_cnt_d    = last_adr ? '0 : tx_cnt_q + 1'b1;
          if (burst_end) begin
            state_d = ST_IDLE;
            if (last_adr) begin
              busy_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    endcase
    cyc_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cyc_q       <= 1'b0;
      tx_cnt_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cyc_q       <= cyc_d;
      tx_cnt_q    <= tx_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign bus.wbm_adr_o = start_adr + (tx_cnt_q << LG_BPW);
  assign bus.wbm_dat_o = '0;
  assign bus.wbm_sel_o = '1;
  assign bus.wbm_we_o  = 1'b0;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_cti_o = !cyc_q ? 3'b000 : (burst_end ? 3'b111 : 3'b010);
  assign bus.wbm_bte_o = 2'b00;

  // Combinational so the FIFO captures the word on the same edge as the ack.
  assign bus.fifo_d  = bus.wbm_dat_i;
  assign bus.fifo_wr = bus.wbm_ack_i & cyc_q & ~bus.wbm_err_i;

  assign busy   = busy_q;
  assign err    = err_q;
  assign tx_cnt = tx_cnt_q;

endmodule
